// File: rtl/load_store_unit_if.sv
// ============================================================================
// Module      : load_store_unit_if
// Description : Core-side request/response and data-memory port bundle for
//               the sub-word load/store adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    // Core plus memory side: issues requests and supplies read data.
    modport master (
        output req, we, funct3, addr, wdata, mem_RD,
        input  busy, done, err, rdata, mem_A, mem_WE, mem_WD
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_RD,
        output busy, done, err, rdata, mem_A, mem_WE, mem_WD
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I sub-word load/store adapter onto a word-wide memory
//               without byte enables (extension on loads, RMW for SB/SH).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit (
    input  wire logic         CLK,
    input  wire logic         rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    state_t      state_q,  state_d;
    logic        we_q,     we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [31:0] merge_q,  merge_d;

    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_mem_we;
    logic [31:0] w_mem_wd;

    // Request checks look at the live bus inputs, since they decide the
    // IDLE transition in the same cycle the request is latched.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (bus.we) begin
            w_illegal = !(bus.funct3 == c_F3_B || bus.funct3 == c_F3_H ||
                          bus.funct3 == c_F3_W);
        end else begin
            w_illegal = !(bus.funct3 == c_F3_B  || bus.funct3 == c_F3_H  ||
                          bus.funct3 == c_F3_W  || bus.funct3 == c_F3_BU ||
                          bus.funct3 == c_F3_HU);
        end
        case (bus.funct3)
            c_F3_H, c_F3_HU: w_misaligned = bus.addr[0];
            c_F3_W:          w_misaligned = |bus.addr[1:0];
            default:         w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    w_byte = bus.mem_RD[7:0];
            2'd1:    w_byte = bus.mem_RD[15:8];
            2'd2:    w_byte = bus.mem_RD[23:16];
            default: w_byte = bus.mem_RD[31:24];
        endcase
        w_half = addr_q[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        case (funct3_q)
            c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load = {24'd0, w_byte};
            c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load = {16'd0, w_half};
            default: w_load = bus.mem_RD;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word comes from
    // the current memory contents.
    always_comb begin
        w_merge = bus.mem_RD;
        if (funct3_q == c_F3_H) begin
            if (addr_q[1]) w_merge[31:16] = wdata_q[15:0];
            else           w_merge[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    w_merge[7:0]   = wdata_q[7:0];
                2'd1:    w_merge[15:8]  = wdata_q[7:0];
                2'd2:    w_merge[23:16] = wdata_q[7:0];
                default: w_merge[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        merge_d  = merge_q;
        w_mem_we = 1'b0;
        w_mem_wd = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d     = bus.we;
                    funct3_d = bus.funct3;
                    addr_d   = bus.addr;
                    wdata_d  = bus.wdata;
                    err_d    = w_illegal | w_misaligned;
                    state_d  = (w_illegal | w_misaligned) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = w_load;
                    state_d = S_RESP;
                end else if (funct3_q == c_F3_W) begin
                    w_mem_we = 1'b1;
                    w_mem_wd = wdata_q;
                    state_d  = S_RESP;
                end else begin
                    merge_d = w_merge;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we = 1'b1;
                w_mem_wd = merge_q;
                state_d  = S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            merge_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            merge_q  <= merge_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_RESP);
    assign bus.err    = (state_q == S_RESP) & err_q;
    assign bus.rdata  = rdata_q;
    assign bus.mem_A  = {2'b00, addr_q[31:2]};
    // Gating with rst kills a pending RMW write in the reset cycle itself.
    assign bus.mem_WE = w_mem_we & ~rst;
    assign bus.mem_WD = w_mem_wd;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench: directed and random accesses against a
//               word-array reference model of RV32I load/store behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Real memory seen by the DUT (64 words at indices 0x2000..0x203F).
    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];
    logic        init_mem = 1'b1;

    assign bus.mem_RD = tb_mem[bus.mem_A[5:0]];

    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= ref_mem[i];
        end else if (bus.mem_WE && bus.mem_A != 32'd0) begin
            tb_mem[bus.mem_A[5:0]] <= bus.mem_WD;
        end
    end

    typedef struct {
        int          issue;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        int          wlat;
        logic [31:0] wa;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = 32'd0;
    int          nwr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done, checks writes as they occur.
    always @(negedge CLK) begin
        if (!rst) begin
            if (bus.mem_WE) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("write_cycle", 32'(cyc - sb[0].issue), 32'(sb[0].wlat));
                    chk("write_addr", bus.mem_A, sb[0].wa);
                    chk("write_data", bus.mem_WD, sb[0].wd);
                    nwr_seen++;
                end
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err", {31'd0, bus.err}, {31'd0, e.err});
                    chk("rdata", bus.rdata, e.rdata);
                    chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    chk("write_count", 32'(nwr_seen), 32'(e.nwr));
                end
                nwr_seen = 0;
            end
        end else begin
            nwr_seen = 0;
        end
    end

    // Reference behaviour from the RV32I rules, evaluated at issue time.
    task automatic model(input logic iwe, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        logic        legal;
        int          sz;
        int          off;
        logic [31:0] word, shifted, v, mask;
        if (iwe) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else     legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        if (legal && (off % sz) != 0) legal = 1'b0;
        word    = ref_mem[a[7:2]];
        shifted = word >> (8 * off);
        e.wa  = {2'b00, a[31:2]};
        e.wd  = 32'd0;
        e.nwr = 0;
        e.wlat = 0;
        if (!legal) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!iwe) begin
            e.err = 1'b0;
            e.lat = 2;
            case (f3)
                3'd0: begin v = shifted & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
                3'd4: v = shifted & 32'hFF;
                3'd1: begin v = shifted & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
                3'd5: v = shifted & 32'hFFFF;
                default: v = word;
            endcase
            model_rdata = v;
        end else begin
            e.err = 1'b0;
            if (sz == 4) mask = 32'hFFFF_FFFF;
            else         mask = ((32'd1 << (8 * sz)) - 32'd1) << (8 * off);
            e.wd   = (word & ~mask) | ((wd << (8 * off)) & mask);
            e.nwr  = 1;
            e.wlat = (sz == 4) ? 1 : 2;
            e.lat  = (sz == 4) ? 2 : 3;
            if (a[31:2] != 30'd0) ref_mem[a[7:2]] = e.wd;
        end
        e.rdata = model_rdata;
    endtask

    // Called at posedge+1; presents req for exactly the sampling cycle.
    task automatic issue(input logic iwe, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit glitch);
        exp_t e;
        int   w;
        w = 0;
        while (bus.busy && w < 20) begin
            @(posedge CLK); #1;
            w++;
        end
        if (bus.busy) begin
            chk("idle_timeout", 32'd1, 32'd0);
            return;
        end
        model(iwe, f3, a, wd, e);
        e.issue    = cyc;
        bus.req    = 1'b1;
        bus.we     = iwe;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = wd;
        sb.push_back(e);
        @(posedge CLK); #1;
        if (glitch) begin
            bus.req    = 1'b1;
            bus.we     = 1'b1;
            bus.funct3 = 3'b010;
            bus.addr   = 32'h0000_8040;
            bus.wdata  = 32'hBAD0_BAD0;
            @(posedge CLK); #1;
        end
        bus.req = 1'b0;
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        int nbad;
        int w;
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h80FF_7F01;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0;
        bus.addr = 32'd0; bus.wdata = 32'd0;

        repeat (3) @(posedge CLK);
        #1;
        rst = 1'b0;
        init_mem = 1'b0;
        chk("reset_busy",   {31'd0, bus.busy},   32'd0);
        chk("reset_done",   {31'd0, bus.done},   32'd0);
        chk("reset_err",    {31'd0, bus.err},    32'd0);
        chk("reset_rdata",  bus.rdata,           32'd0);
        chk("reset_mem_we", {31'd0, bus.mem_WE}, 32'd0);

        issue(1'b0, 3'b000, 32'h8003, 32'd0, 1'b0);
        issue(1'b0, 3'b100, 32'h8003, 32'd0, 1'b0);
        issue(1'b0, 3'b000, 32'h8000, 32'd0, 1'b0);
        issue(1'b0, 3'b001, 32'h8002, 32'd0, 1'b0);
        issue(1'b0, 3'b101, 32'h8002, 32'd0, 1'b0);
        issue(1'b0, 3'b001, 32'h8001, 32'd0, 1'b0);
        issue(1'b1, 3'b010, 32'h8000, 32'h1122_3344, 1'b0);
        issue(1'b1, 3'b000, 32'h8001, 32'h0000_00AB, 1'b0);
        issue(1'b0, 3'b010, 32'h8000, 32'd0, 1'b0);
        issue(1'b1, 3'b001, 32'h8002, 32'h0000_BEEF, 1'b0);
        issue(1'b0, 3'b010, 32'h8000, 32'd0, 1'b0);
        issue(1'b1, 3'b010, 32'h8000, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 3'b010, 32'h8002, 32'h0BAD_F00D, 1'b0);
        issue(1'b1, 3'b100, 32'h8004, 32'h5555_5555, 1'b0);
        issue(1'b0, 3'b011, 32'h8004, 32'd0, 1'b0);
        issue(1'b0, 3'b010, 32'h8000, 32'd0, 1'b1);
        issue(1'b1, 3'b000, 32'h8005, 32'h0000_0077, 1'b1);

        // Reset during the WRITE cycle of an SB: no write, no done.
        w = 0;
        while (bus.busy && w < 20) begin @(posedge CLK); #1; w++; end
        chk("rmw_start_idle", {31'd0, bus.busy}, 32'd0);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000;
        bus.addr = 32'h8001; bus.wdata = 32'h0000_00CD;
        @(posedge CLK); #1;
        bus.req = 1'b0;
        @(posedge CLK); #1;
        rst = 1'b1;
        @(negedge CLK);
        chk("rst_write_blocked", {31'd0, bus.mem_WE}, 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;
        model_rdata = 32'd0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        issue(1'b0, 3'b010, 32'h8000, 32'd0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic        rw;
            logic [2:0]  f3;
            logic [31:0] a;
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (rw)                   f3 = legal_f3[$urandom_range(0, 2)];
            else                           f3 = legal_f3[$urandom_range(0, 4)];
            a = 32'h8000 + 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
            end
            issue(rw, f3, a, $urandom, ($urandom_range(0, 15) == 0) && f3 == 3'd2 && a[1:0] == 2'd0);
        end

        w = 0;
        while (sb.size() != 0 && w < 20) begin @(posedge CLK); #1; w++; end
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        nbad = 0;
        for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store adapter between the RV32I core's memory-stage signals and the word-wide data memory. The data memory is word-indexed, has a combinational read port and no byte enables. This block therefore converts byte addresses to word indices and performs sign/zero extension for LB/LH/LBU/LHU. It executes SB/SH as a read-modify-write sequence and flags misaligned or illegal accesses. A small FSM sequences each access, and the core stalls on `busy`.

## Interface
- No parameters; all widths fixed: 32-bit data, 32-bit byte address.
- `CLK` input 1: sole clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: access request, sampled only in IDLE.
- `we` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `addr` input 32: byte address.
- `wdata` input 32: store data, right-aligned.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse, access complete.
- `err` output 1: valid with `done`; misaligned access or illegal funct3.
- `rdata` output 32: extended load result; held until the next `done`.
- `mem_A` output 32: word index, `{2'b00, addr_q[31:2]}`.
- `mem_WE` output 1: memory write enable.
- `mem_WD` output 32: memory write data.
- `mem_RD` input 32: combinational memory read data for `mem_A`.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req`=1: latch `we`, `funct3`, `addr`, `wdata` into `*_q`.
  - Misaligned or illegal: go to RESP with `err_q`=1.
    - Misaligned: H/HU/SH with addr[0]=1; W with addr[1:0]≠0.
    - Illegal: load funct3 ∈ {011,110,111}; store funct3 ∉ {000,001,010}.
  - Otherwise go to ACCESS.
  - `req`=0: stay in IDLE.
- **ACCESS**
  - Load:
    - Select the byte lane (little-endian) at `addr_q[1:0]` or the halfword at `addr_q[1]`.
    - Sign-extend for B/H; zero-extend for BU/HU.
    - Register the result into `rdata`; go to RESP.
  - SW: `mem_WE`=1, `mem_WD`=`wdata_q`; go to RESP.
  - SB/SH:
    - Merge `wdata_q[7:0]` or `wdata_q[15:0]` into `mem_RD` at the addressed lane; other bytes unchanged.
    - Register the merged word into `merge_q`; go to WRITE.
- **WRITE:** `mem_WE`=1, `mem_WD`=`merge_q`; go to RESP.
- **RESP**
  - `done`=1 and `err`=`err_q`; return to IDLE.
  - `rdata` is updated only by loads. Stores and errors leave it unchanged.
- **`mem_A`:** derived from `addr_q` in all states; value irrelevant in IDLE.
- **Word index 0:** no special case. The memory itself ignores writes to index 0.
- **`mem_WE`:** 0 in IDLE, RESP, on load ACCESS, and on error paths. It is forced to 0 while `rst`=1.

## Timing
- **Reset:** state=IDLE; `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_WE`=0; `merge_q`=0; latched request registers =0.
- **Latency from the req cycle (cycle 0):**
  - Load and SW: `done` in cycle 2. SW memory write commits at the end of cycle 1.
  - SB/SH: `done` in cycle 3; write commits at the end of cycle 2.
  - Error: `done`+`err` in cycle 1, with no memory access.
- **`busy`:** rises in cycle 1 and falls in the cycle after `done`. Back-to-back requests are possible one cycle after `done`.
- **`req` while busy:** ignored, not queued. The core must hold `req` until it sees `done`.
- **RMW atomicity:** the read (ACCESS) and write (WRITE) are consecutive cycles with no other memory master.
- **Reset mid-operation:** any state returns to IDLE. A pending WRITE is aborted with no write, and no `done` is issued.
- **`done` in RESP with `req` high:** that `req` is not sampled; it is accepted in the following IDLE cycle.

## Test plan
- **LB/LBU:** mem word 0x2000 = 0x80FF7F01.
  - LB @0x8003 -> `rdata`=0xFFFFFF80.
  - LBU @0x8003 -> 0x00000080.
  - LB @0x8000 -> 0x00000001.
  - `done` in cycle 2, `err`=0.
- **LH/LHU:** same word.
  - LH @0x8002 -> 0xFFFF80FF.
  - LHU @0x8002 -> 0x000080FF.
  - LH @0x8001 -> `err`=1 in cycle 1, `rdata` unchanged.
- **SB RMW:** word = 0x11223344, SB `wdata`=0xAB @0x8001.
  - `mem_WE` high only in cycle 2 with `mem_WD`=0x1122AB44; `done` in cycle 3.
  - Follow-up LW -> 0x1122AB44.
- **SH/SW:**
  - SH 0xBEEF @0x8002 -> word becomes 0xBEEFAB44.
  - SW 0xDEADBEEF @0x8000 -> `mem_WE` in cycle 1 only, `done` in cycle 2.
  - SW @0x8002 -> `err`, no write.
- **Illegal funct3:**
  - Store funct3=100 -> `err` in cycle 1, `mem_WE` never high.
  - Load funct3=011 -> `err`.
- **Reset mid-RMW:** assert `rst` during WRITE of an SB to 0x8001 -> no `mem_WE` pulse, word unchanged, `busy`=0 next cycle, no `done`.
- **Req while busy:** a new `req` during ACCESS is ignored; it is accepted only in IDLE after `done`.
